// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Hazard and sequencing controller for a 5-stage RISC pipeline
// (IF/ID/EX/MEM/WB).
//   * Produces the per-stage stall and flush enables.
//   * Selects the EX-stage forwarding sources.
//   * Holds the whole pipeline while a data memory access is pending.
//   * A watchdog latches a sticky error if a memory access never completes.
//   * Keeps saturating counters of stall cycles and taken-branch flushes.
//
// Ports
//   clk, rst              clock; asynchronous active-low reset
//   id_*                  source registers read by the instruction in ID
//   ex_*                  operands, destination and control of the EX instruction
//   mem_rd/mem_reg_write  destination register and RegWrite in MEM
//   wb_rd/wb_reg_write    destination register and RegWrite in WB
//   mem_req, mem_ready    data memory handshake
//   stall_if..stall_mem   hold the PC and the IF/ID, ID/EX and EX/MEM registers
//   flush_id, flush_ex    clear the IF/ID and ID/EX control bits
//   fwd_a, fwd_b          EX operand select (00 regfile, 10 MEM, 01 WB)
//   mem_err               sticky memory timeout error
//   stall_cnt, flush_cnt  saturating performance counters
//   state                 FSM state (RUN=0, WAIT=1, ERROR=2)
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_reg_write,
  input  logic [1:0]       ex_result_src,
  input  logic             ex_branch,
  input  logic             ex_zero,
  input  logic [4:0]       mem_rd,
  input  logic             mem_reg_write,
  input  logic [4:0]       wb_rd,
  input  logic             wb_reg_write,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             stall_mem,
  output logic             flush_id,
  output logic             flush_ex,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    WAIT  = 2'd1,
    ERROR = 2'd2
  } state_t;

  // Wide enough to hold MEM_TIMEOUT-1 for any legal MEM_TIMEOUT.
  localparam int TO_W = $clog2(MEM_TIMEOUT + 1);

  state_t           state_reg;
  logic [TO_W-1:0]  to_cnt_reg;
  logic             mem_err_reg;
  logic [CNT_W-1:0] stall_cnt_reg;
  logic [CNT_W-1:0] flush_cnt_reg;

  logic mw;
  logic taken;
  logic lu;

  assign mw    = mem_req & ~mem_ready;
  assign taken = ex_branch & ex_zero;
  assign lu    = ex_reg_write & (ex_result_src == 2'b01) & (ex_rd != 5'd0) &
                 ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

  // ---------------------------------------------------------------------------
  // Stall / flush generation (strict priority, same-cycle).
  // stall_front covers IF and ID, stall_back covers EX and MEM.
  // ---------------------------------------------------------------------------
  logic stall_front;
  logic stall_back;
  logic flush_id_c;
  logic flush_ex_c;
  logic flush_taken;

  always_comb begin
    stall_front = 1'b0;
    stall_back  = 1'b0;
    flush_id_c  = 1'b0;
    flush_ex_c  = 1'b0;
    flush_taken = 1'b0;
    if (!rst) begin
      // Controls stay quiet while reset is asserted.
    end else if (state_reg == ERROR || mw) begin
      // Branches and load-uses are re-presented by the held registers later.
      stall_front = 1'b1;
      stall_back  = 1'b1;
    end else if (taken) begin
      // A load-use behind a taken branch is on the wrong path: flush wins.
      flush_id_c  = 1'b1;
      flush_ex_c  = 1'b1;
      flush_taken = 1'b1;
    end else if (lu) begin
      // Hold IF/ID and push a bubble into EX for one cycle.
      stall_front = 1'b1;
      flush_ex_c  = 1'b1;
    end
  end

  assign stall_if  = stall_front;
  assign stall_id  = stall_front;
  assign stall_ex  = stall_back;
  assign stall_mem = stall_back;
  assign flush_id  = flush_id_c;
  assign flush_ex  = flush_ex_c;

  // ---------------------------------------------------------------------------
  // Forwarding: one identical selector per EX operand, MEM beats WB.
  // ---------------------------------------------------------------------------
  logic [4:0] ex_src  [2];
  logic [1:0] fwd_sel [2];

  assign ex_src[0] = ex_rs1;
  assign ex_src[1] = ex_rs2;

  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    assign fwd_sel[gi] =
      (mem_reg_write && mem_rd != 5'd0 && mem_rd == ex_src[gi]) ? 2'b10 :
      (wb_reg_write  && wb_rd  != 5'd0 && wb_rd  == ex_src[gi]) ? 2'b01 :
                                                                   2'b00;
  end

  assign fwd_a = fwd_sel[0];
  assign fwd_b = fwd_sel[1];

  // ---------------------------------------------------------------------------
  // Memory wait FSM with watchdog. to_cnt_reg counts consecutive waiting
  // cycles; the entry cycle counts as 1, so ERROR is reached MEM_TIMEOUT-1
  // edges after entering WAIT.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= RUN;
      to_cnt_reg  <= '0;
      mem_err_reg <= 1'b0;
    end else begin
      case (state_reg)
        RUN: begin
          if (mw) begin
            state_reg  <= WAIT;
            to_cnt_reg <= TO_W'(1);
          end
        end
        WAIT: begin
          if (!mw) begin
            // Completed, or mem_req dropped (tolerated protocol violation).
            state_reg  <= RUN;
            to_cnt_reg <= '0;
          end else if (to_cnt_reg == TO_W'(MEM_TIMEOUT - 1)) begin
            state_reg   <= ERROR;
            mem_err_reg <= 1'b1;
          end else begin
            to_cnt_reg <= to_cnt_reg + TO_W'(1);
          end
        end
        ERROR: begin
          // Absorbing; only reset leaves this state.
          mem_err_reg <= 1'b1;
        end
        default: begin
          state_reg  <= RUN;
          to_cnt_reg <= '0;
        end
      endcase
    end
  end

  assign state   = state_reg;
  assign mem_err = mem_err_reg;

  // ---------------------------------------------------------------------------
  // Saturating performance counters.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (stall_front && stall_cnt_reg != '1)
        stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      if (flush_taken && flush_cnt_reg != '1)
        flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;

endmodule
